// File: rtl/mnist_pixel_streamer_if.sv
// Activation stream from the pixel streamer into the first dense layer.
// One beat per cycle where out_valid and out_ready are both high.
interface mnist_pixel_streamer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic [9:0]            out_index;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output out_data,
        output out_index,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_index,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mnist_pixel_streamer.sv
// Snapshots the 28x28 drawing grid on start and streams it, pixel by pixel in
// ascending index order, as Q1.7 activations. Counts set pixels on the way and
// pulses done once the final beat has been accepted.
module mnist_pixel_streamer #(
    parameter int                     GRID_SIZE  = 28,
    parameter int                     DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]  ONE_VALUE  = 8'd127,
    parameter logic [DATA_WIDTH-1:0]  ZERO_VALUE = 8'd0
) (
    input  logic                                 CLOCK_50,
    input  logic                                 resetn,
    input  logic                                 start,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]       pixel_memory,
    mnist_pixel_streamer_if.master               stream,
    output logic                                 busy,
    output logic                                 done,
    output logic [9:0]                           pixel_count
);

    localparam int         NUM_PIXELS = GRID_SIZE * GRID_SIZE;
    localparam logic [9:0] LAST_INDEX = 10'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [NUM_PIXELS-1:0]   snapshot_q;
    logic [9:0]              index_q;
    logic [9:0]              count_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    valid_q;
    logic                    last_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    accept;
    logic [9:0]              index_d;
    logic [DATA_WIDTH-1:0]   data_d;
    logic                    last_d;
    logic [9:0]              count_d;

    // Next-beat values, precomputed so every stream output comes straight from a flop.
    always_comb begin
        accept  = valid_q & stream.out_ready;
        index_d = index_q + 10'd1;
        data_d  = ZERO_VALUE;
        if (index_d <= LAST_INDEX) begin
            data_d = snapshot_q[index_d] ? ONE_VALUE : ZERO_VALUE;
        end
        last_d  = (index_d == LAST_INDEX);
        count_d = count_q + {9'd0, snapshot_q[index_q]};
    end

    // Control FSM with registered outputs; a mid-stream reset drops everything at once.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            snapshot_q <= '0;
            index_q    <= '0;
            count_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Capture the grid now; later edits to pixel_memory never reach the stream.
                        snapshot_q <= pixel_memory;
                        index_q    <= '0;
                        count_q    <= '0;
                        data_q     <= pixel_memory[0] ? ONE_VALUE : ZERO_VALUE;
                        last_q     <= (LAST_INDEX == 10'd0);
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= STREAM;
                    end
                end
                STREAM: begin
                    // Without acceptance every stream output simply holds.
                    if (accept) begin
                        count_q <= count_d;
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            data_q  <= ZERO_VALUE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            index_q <= index_d;
                            data_q  <= data_d;
                            last_q  <= last_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stream.out_data  = data_q;
    assign stream.out_index = index_q;
    assign stream.out_valid = valid_q;
    assign stream.out_last  = last_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pixel_count      = count_q;

endmodule

// File: tb/tb_mnist_pixel_streamer.sv
// Directed bench for mnist_pixel_streamer: reset, full-rate stream, backpressure,
// snapshot isolation, reset mid-stream and back-to-back starts.
module tb_mnist_pixel_streamer;

    logic         CLOCK_50 = 1'b0;
    logic         resetn   = 1'b1;
    logic         start    = 1'b0;
    logic [783:0] pixel_memory = '0;
    logic         busy;
    logic         done;
    logic [9:0]   pixel_count;

    int n_cmp = 0;
    int n_mis = 0;

    mnist_pixel_streamer_if #(.DATA_WIDTH(8)) sif ();

    mnist_pixel_streamer dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .start        (start),
        .pixel_memory (pixel_memory),
        .stream       (sif),
        .busy         (busy),
        .done         (done),
        .pixel_count  (pixel_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " start busy"},  int'(busy), 1);
        check({tag, " start valid"}, int'(sif.out_valid), 1);
        check({tag, " start index"}, int'(sif.out_index), 0);
        check({tag, " start count"}, int'(pixel_count), 0);
    endtask

    // Drives out_ready and checks every beat; rmode 0 = always ready, 1 = 1,0,0,1 pattern.
    task automatic consume(input string tag, input logic [783:0] snap, input int rmode,
                           input int stop_at, input bit mutate, input int exp_count,
                           output int beats, output int dones);
        bit stalled = 1'b0;
        bit finished = 1'b0;
        bit stopped = 1'b0;
        int p_idx = 0;
        int p_data = 0;
        int p_last = 0;
        beats = 0;
        dones = 0;
        for (int cyc = 0; cyc < 4000 && !finished && !stopped; cyc++) begin
            if (stop_at >= 0 && beats == stop_at) begin
                check({tag, " stop index"}, int'(sif.out_index), stop_at);
                stopped = 1'b1;
            end else begin
                sif.out_ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
                if (mutate && cyc == 5) begin
                    pixel_memory = '1;
                    start = 1'b1;
                end else if (mutate && cyc == 6) begin
                    start = 1'b0;
                end
                check({tag, " valid"}, int'(sif.out_valid), 1);
                check({tag, " busy"},  int'(busy), 1);
                if (stalled) begin
                    check({tag, " hold index"}, int'(sif.out_index), p_idx);
                    check({tag, " hold data"},  int'(sif.out_data),  p_data);
                    check({tag, " hold last"},  int'(sif.out_last),  p_last);
                end
                p_idx  = int'(sif.out_index);
                p_data = int'(sif.out_data);
                p_last = int'(sif.out_last);
                if (sif.out_ready) begin
                    check({tag, " index"}, int'(sif.out_index), beats);
                    check({tag, " data"},  int'(sif.out_data), snap[beats] ? 127 : 0);
                    check({tag, " last"},  int'(sif.out_last), (beats == 783) ? 1 : 0);
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                end
                tick();
                if (beats == 784) begin
                    check({tag, " done"},       int'(done), 1);
                    check({tag, " done busy"},  int'(busy), 0);
                    check({tag, " done valid"}, int'(sif.out_valid), 0);
                    check({tag, " done last"},  int'(sif.out_last), 0);
                    check({tag, " count"},      int'(pixel_count), exp_count);
                    dones++;
                    tick();
                    check({tag, " done drop"},  int'(done), 0);
                    check({tag, " count hold"}, int'(pixel_count), exp_count);
                    finished = 1'b1;
                end else begin
                    check({tag, " no early done"}, int'(done), 0);
                end
            end
        end
        if (!finished && !stopped) begin
            check({tag, " timeout beats"}, beats, 784);
        end
    endtask

    initial begin
        logic [783:0] img_a;
        logic [783:0] img_b;
        logic [783:0] img_c;
        int beats;
        int dones;

        img_a = '0;
        img_a[0] = 1'b1;
        img_a[29] = 1'b1;
        img_a[783] = 1'b1;
        img_b = '0;
        for (int i = 0; i < 784; i += 3) img_b[i] = 1'b1;
        img_c = '0;
        for (int i = 700; i < 784; i++) img_c[i] = 1'b1;
        sif.out_ready = 1'b0;

        // Asynchronous reset asserted between edges
        #2 resetn = 1'b0;
        #1;
        check("rst valid", int'(sif.out_valid), 0);
        check("rst last",  int'(sif.out_last), 0);
        check("rst busy",  int'(busy), 0);
        check("rst done",  int'(done), 0);
        check("rst data",  int'(sif.out_data), 0);
        check("rst index", int'(sif.out_index), 0);
        check("rst count", int'(pixel_count), 0);
        tick();
        tick();
        resetn = 1'b1;
        sif.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle valid", int'(sif.out_valid), 0);
            check("idle busy",  int'(busy), 0);
        end

        // Full-speed stream, three set pixels
        pixel_memory = img_a;
        do_start("full");
        consume("full", img_a, 0, -1, 1'b0, 3, beats, dones);
        check("full beats", beats, 784);
        check("full dones", dones, 1);

        // Back-to-back start the cycle after done, all-ones image under backpressure
        pixel_memory = '1;
        do_start("bp");
        consume("bp", '1, 1, -1, 1'b0, 784, beats, dones);
        check("bp beats", beats, 784);
        check("bp dones", dones, 1);

        // Snapshot isolation and ignored start during STREAM
        pixel_memory = '0;
        do_start("iso");
        consume("iso", '0, 0, -1, 1'b1, 0, beats, dones);
        check("iso beats", beats, 784);
        check("iso dones", dones, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("iso no restart", int'(sif.out_valid), 0);
            check("iso no done",    int'(done), 0);
        end

        // Reset at beat 400 aborts without done
        pixel_memory = img_b;
        do_start("abort");
        consume("abort", img_b, 0, 400, 1'b0, 0, beats, dones);
        resetn = 1'b0;
        #1;
        check("abort valid", int'(sif.out_valid), 0);
        check("abort busy",  int'(busy), 0);
        check("abort index", int'(sif.out_index), 0);
        check("abort count", int'(pixel_count), 0);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort no done",  int'(done), 0);
            check("abort no valid", int'(sif.out_valid), 0);
        end

        // Fresh stream after the abort recounts from zero
        pixel_memory = img_c;
        do_start("recount");
        consume("recount", img_c, 0, -1, 1'b0, 84, beats, dones);
        check("recount beats", beats, 784);
        check("recount dones", dones, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mnist_pixel_streamer.md
Name: mnist_pixel_streamer

Overview:
Downstream stage of the 28x28 drawing grid. Takes a snapshot of the 784-bit `pixel_memory` when `start` is pulsed. Streams the pixels in ascending index order as fixed-point activations over a valid/ready interface into the first dense layer of the network. Also reports how many pixels were set and signals completion, so the inference controller can begin accumulation.

Parameters:
- GRID_SIZE, 28, grid edge length; NUM_PIXELS = GRID_SIZE*GRID_SIZE = 784.
- DATA_WIDTH, 8, width of each streamed activation.
- ONE_VALUE, 8'd127, activation emitted for a set pixel (Q1.7 "1.0").
- ZERO_VALUE, 8'd0, activation emitted for a clear pixel.

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to snapshot and stream; honoured only in IDLE.
- pixel_memory  input  784  drawing grid; bit y*GRID_SIZE+x is pixel (x,y); 1 = drawn.
- out_data  output  DATA_WIDTH  activation for pixel out_index.
- out_index  output  10  pixel index 0..783 of current beat.
- out_valid  output  1  beat present.
- out_ready  input  1  consumer accepts the beat when high together with out_valid.
- out_last  output  1  high with the beat whose out_index = 783.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last beat is accepted.
- pixel_count  output  10  number of set pixels in the snapshot; valid from the done pulse until the next accepted start.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE.
  - out_valid=0, out_last=0, busy=0, done=0.
  - out_data=0, out_index=0, pixel_count=0.
  - Snapshot register cleared.
  - Reset mid-stream aborts immediately; no done pulse is issued.
- State IDLE:
  - When start=1, on that edge: copy pixel_memory into the internal 784-bit snapshot, clear index and count, go to STREAM.
  - Set busy=1 on the same edge.
- State STREAM:
  - out_valid=1 from the first cycle in STREAM, so first-beat latency from start is 1 cycle.
  - out_data = snapshot[out_index] ? ONE_VALUE : ZERO_VALUE.
  - out_last = (out_index == NUM_PIXELS-1).
  - Beat accepted on an edge where out_valid & out_ready:
    - pixel_count increments if the accepted bit is 1.
    - If not last: out_index increments and the next beat is presented the following cycle.
    - If last: go to DONE and drop out_valid and out_last.
  - While out_valid=1 and out_ready=0: out_data, out_index and out_last hold stable (no glitching, no skipping).
  - out_ready held high gives exactly 784 consecutive beats, one per cycle.
- State DONE (one cycle):
  - done=1, busy=0, out_valid=0; pixel_count holds the final total; next state IDLE.
- Snapshot isolation: changes to pixel_memory after start is accepted do not affect the stream.
- start asserted in STREAM or DONE is ignored; it is not queued.
- start in IDLE at the same edge as a pixel_memory change captures the pre-edge value of pixel_memory.
- pixel_count range 0..784; 784 fits in 10 bits, so no saturation is needed.
- out_ready may be high while out_valid is low; this has no effect.
- Minimum start-to-done time is 786 cycles: 1 cycle to load, 784 beats, then done in the following cycle.

Test Plan:
- Reset/idle: resetn=0 asynchronously mid-cycle → all outputs 0 immediately. Release with start=0 for 10 cycles → out_valid stays 0.
- Full-speed stream: pixel_memory has only bits 0, 29 and 783 set; start pulse; out_ready=1 →
  - 784 beats on consecutive cycles, first beat 1 cycle after start.
  - out_data=127 only at indices 0, 29 and 783, out_last only at index 783.
  - done pulse 1 cycle after the last beat, pixel_count=3.
- Backpressure: all-ones image; out_ready toggles 1,0,0,1 repeating → every index 0..783 seen exactly once, data held stable during stalls, pixel_count=784.
- Snapshot isolation and ignored start: all-zero image captured; pixel_memory switched to all ones and start re-pulsed during STREAM → all beats out_data=0, pixel_count=0, exactly one done pulse.
- Reset mid-stream: resetn asserted at beat 400 → out_valid=0 and busy=0 at once, no done pulse. A new start then streams from index 0 with pixel_count recounted.
- Back-to-back: start pulsed the cycle after done → second stream begins normally, pixel_count cleared and recomputed for the new snapshot.
